rr_mux_sel_ctrl: RTL and testbench



---
 rtl/rr_mux_sel_ctrl.sv | 115 +++++++++++
 tb/tb_rr_mux_sel_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/rr_mux_sel_ctrl.sv
// Round-robin select controller for a K-to-1 word mux: arbitrates req, drives sel,
// captures the returned word into a registered valid/ready slot and acks the served lane.
module rr_mux_sel_ctrl #(
    parameter  int unsigned K    = 4,
    parameter  int unsigned SIZE = 16,
    localparam int unsigned BIT  = (K > 1) ? $clog2(K) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [K-1:0]    req,
    output logic [BIT-1:0]  sel,
    input  logic [SIZE-1:0] mux_out,
    output logic [K-1:0]    ack,
    output logic [SIZE-1:0] out_data,
    output logic            out_valid,
    input  logic            out_ready
);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_CAPTURE = 1'b1
    } state_t;

    state_t          r_state;
    logic [BIT-1:0]  r_sel;
    logic [K-1:0]    r_ack;
    logic [SIZE-1:0] r_out_data;
    logic            r_out_valid;
    logic [BIT-1:0]  r_last_grant;

    state_t          w_state_nxt;
    logic [BIT-1:0]  w_sel_nxt;
    logic [K-1:0]    w_ack_nxt;
    logic [SIZE-1:0] w_out_data_nxt;
    logic            w_out_valid_nxt;
    logic [BIT-1:0]  w_last_grant_nxt;

    logic            w_slot_free;
    logic            w_found;
    logic [BIT-1:0]  w_winner;
    int unsigned     w_cand;

    assign w_slot_free = !r_out_valid || out_ready;

    // First set request scanning upward from the lane after last_grant, modulo K.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_cand   = 0;
        for (int unsigned off = 1; off <= K; off++) begin
            w_cand = 32'(r_last_grant) + off;
            if (w_cand >= K) begin
                w_cand = w_cand - K;
            end
            if (!w_found && req[BIT'(w_cand)]) begin
                w_found  = 1'b1;
                w_winner = BIT'(w_cand);
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt      = r_state;
        w_sel_nxt        = r_sel;
        w_ack_nxt        = '0;
        w_out_data_nxt   = r_out_data;
        w_out_valid_nxt  = r_out_valid && !out_ready;
        w_last_grant_nxt = r_last_grant;

        case (r_state)
            ST_IDLE: begin
                if (w_found && w_slot_free) begin
                    w_sel_nxt   = w_winner;
                    w_state_nxt = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                w_out_data_nxt   = mux_out;
                w_out_valid_nxt  = 1'b1;
                w_ack_nxt        = K'(1) << r_sel;
                w_last_grant_nxt = r_sel;
                w_state_nxt      = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // last_grant resets to K-1 so lane 0 holds first priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_sel        <= '0;
            r_ack        <= '0;
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
            r_last_grant <= BIT'(K - 1);
        end else begin
            r_state      <= w_state_nxt;
            r_sel        <= w_sel_nxt;
            r_ack        <= w_ack_nxt;
            r_out_data   <= w_out_data_nxt;
            r_out_valid  <= w_out_valid_nxt;
            r_last_grant <= w_last_grant_nxt;
        end
    end

    assign sel       = r_sel;
    assign ack       = r_ack;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_rr_mux_sel_ctrl.sv
// Directed bench for rr_mux_sel_ctrl: K=4/SIZE=16 and K=3/SIZE=8 instances with
// behavioural mux models; expected values are hand-computed per step.
module tb_rr_mux_sel_ctrl;

    logic clk;
    logic rst_n;

    logic [3:0]  req4;
    logic [1:0]  sel4;
    logic [15:0] mux4;
    logic [3:0]  ack4;
    logic [15:0] data4;
    logic        valid4;
    logic        ready4;

    logic [2:0]  req3;
    logic [1:0]  sel3;
    logic [7:0]  mux3;
    logic [2:0]  ack3;
    logic [7:0]  data3;
    logic        valid3;
    logic        ready3;

    int total = 0;
    int bad   = 0;

    logic [15:0] w4 [4];
    logic [7:0]  w3 [3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        mux4 = w4[sel4];
        case (sel3)
            2'd0:    mux3 = w3[0];
            2'd1:    mux3 = w3[1];
            2'd2:    mux3 = w3[2];
            default: mux3 = 8'hEE;
        endcase
    end

    rr_mux_sel_ctrl #(.K(4), .SIZE(16)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .req(req4), .sel(sel4), .mux_out(mux4),
        .ack(ack4), .out_data(data4), .out_valid(valid4), .out_ready(ready4)
    );

    rr_mux_sel_ctrl #(.K(3), .SIZE(8)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .req(req3), .sel(sel3), .mux_out(mux3),
        .ack(ack3), .out_data(data3), .out_valid(valid3), .out_ready(ready3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        req4  = '0;
        req3  = '0;
        #2;
        chk("rst_sel",   32'(sel4),   32'h0);
        chk("rst_ack",   32'(ack4),   32'h0);
        chk("rst_data",  32'(data4),  32'h0);
        chk("rst_valid", 32'(valid4), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        w4[0] = 16'hDDDD; w4[1] = 16'hCCCC; w4[2] = 16'hBBBB; w4[3] = 16'hAAAA;
        w3[0] = 8'h11;    w3[1] = 8'h22;    w3[2] = 8'h33;
        rst_n  = 1'b0;
        req4   = '0;
        req3   = '0;
        ready4 = 1'b1;
        ready3 = 1'b1;
        #12;

        // Single request on lane 2
        do_reset();
        req4 = 4'b0100;
        tick();
        chk("t1_sel",    32'(sel4),   32'h2);
        chk("t1_valid0", 32'(valid4), 32'h0);
        chk("t1_ack0",   32'(ack4),   32'h0);
        tick();
        chk("t1_data",  32'(data4),  32'hBBBB);
        chk("t1_valid", 32'(valid4), 32'h1);
        chk("t1_ack",   32'(ack4),   32'b0100);
        req4 = 4'b0000;
        tick();
        chk("t1_ack_pulse", 32'(ack4),   32'h0);
        chk("t1_consumed",  32'(valid4), 32'h0);
        chk("t1_data_keep", 32'(data4),  32'hBBBB);

        // All lanes requesting: rotation 0,1,2,3,0
        do_reset();
        req4 = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t2_sel",   32'(sel4),   32'(i % 4));
            chk("t2_gap",   32'(ack4),   32'h0);
            chk("t2_idlev", 32'(valid4), 32'h0);
            tick();
            chk("t2_data",  32'(data4),  32'(w4[i % 4]));
            chk("t2_ack",   32'(ack4),   32'(1 << (i % 4)));
            chk("t2_valid", 32'(valid4), 32'h1);
        end

        // last_grant=1, req=1010: lane 3, lane 1, lane 3, lane 1; lane 0 never acked
        do_reset();
        req4 = 4'b0010;
        tick();
        tick();
        chk("t3_pre_ack", 32'(ack4), 32'b0010);
        req4 = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t3_sel",  32'(sel4), (i % 2 == 0) ? 32'h3 : 32'h1);
            tick();
            chk("t3_data", 32'(data4), (i % 2 == 0) ? 32'hAAAA : 32'hCCCC);
            chk("t3_ack",  32'(ack4),  (i % 2 == 0) ? 32'b1000 : 32'b0010);
        end

        // Backpressure: out_ready low holds the first word
        do_reset();
        ready4 = 1'b0;
        req4   = 4'b1111;
        tick();
        tick();
        chk("t4_data0", 32'(data4), 32'hDDDD);
        chk("t4_ack0",  32'(ack4),  32'b0001);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t4_hold_valid", 32'(valid4), 32'h1);
            chk("t4_hold_data",  32'(data4),  32'hDDDD);
            chk("t4_hold_sel",   32'(sel4),   32'h0);
            chk("t4_hold_ack",   32'(ack4),   32'h0);
        end
        ready4 = 1'b1;
        tick();
        chk("t4_rel_sel",   32'(sel4),   32'h1);
        chk("t4_rel_valid", 32'(valid4), 32'h0);
        tick();
        chk("t4_rel_data", 32'(data4),  32'hCCCC);
        chk("t4_rel_ack",  32'(ack4),   32'b0010);
        chk("t4_rel_vld",  32'(valid4), 32'h1);

        // Request withdrawn between grant and capture
        do_reset();
        req4 = 4'b0100;
        tick();
        req4 = 4'b0000;
        tick();
        chk("t5_ack",   32'(ack4),   32'b0100);
        chk("t5_data",  32'(data4),  32'hBBBB);
        chk("t5_valid", 32'(valid4), 32'h1);

        // K=3, SIZE=8: sel 0,1,2,0,1,2 and never 3
        do_reset();
        req3 = 3'b111;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t6_sel", 32'(sel3), 32'(i % 3));
            tick();
            chk("t6_sel_hold", 32'(sel3),  32'(i % 3));
            chk("t6_data",     32'(data3), 32'(w3[i % 3]));
            chk("t6_ack",      32'(ack3),  32'(1 << (i % 3)));
        end
        req3 = '0;

        // Asynchronous reset while in CAPTURE
        do_reset();
        req4 = 4'b0100;
        tick();
        tick();
        req4 = 4'b1000;
        tick();
        chk("t7_pre_sel", 32'(sel4), 32'h3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t7_sel",   32'(sel4),   32'h0);
        chk("t7_data",  32'(data4),  32'h0);
        chk("t7_valid", 32'(valid4), 32'h0);
        chk("t7_ack",   32'(ack4),   32'h0);
        tick();
        chk("t7_dropped", 32'(valid4), 32'h0);
        rst_n = 1'b1;
        req4  = 4'b1001;
        tick();
        chk("t7_first_sel", 32'(sel4), 32'h0);
        tick();
        chk("t7_first_data", 32'(data4), 32'hDDDD);
        chk("t7_first_ack",  32'(ack4),  32'b0001);
        req4 = 4'b0000;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
